// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: FSM encoding, status word layout and
// ring-buffer index helpers.
package fir_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StOut   = 3'd4
    } fir_state_e;

    localparam int unsigned StatStateLsb    = 0;
    localparam int unsigned StatBusyBit     = 3;
    localparam int unsigned StatCoeffErrBit = 4;
    localparam int unsigned StatSatBit      = 5;
    localparam int unsigned StatTapLsb      = 8;
    localparam int unsigned StatTapWidth    = 8;

    // (a - b) mod n, for a, b already in [0, n)
    function automatic int unsigned ring_sub(int unsigned a, int unsigned b, int unsigned n);
        return (a >= b) ? (a - b) : (a + n - b);
    endfunction

    function automatic int unsigned ring_inc(int unsigned a, int unsigned n);
        return (a + 1 >= n) ? 0 : (a + 1);
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Stream and MAC-operand signals of the FIR MAC sequencer. The slave modport is the
// sequencer's view; master is the environment (source, MAC unit, sink).
interface fir_mac_sequencer_if #(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned COEFF_WIDTH = 18,
    parameter int unsigned ACC_WIDTH   = 48
);
    logic [DATA_WIDTH-1:0]  s_data;
    logic                   s_valid;
    logic                   s_ready;

    logic [DATA_WIDTH-1:0]  mac_data;
    logic [COEFF_WIDTH-1:0] mac_coeff;
    logic                   mac_valid;
    logic                   mac_clear;
    logic                   mac_ready;
    logic [ACC_WIDTH-1:0]   mac_acc;
    logic                   mac_acc_valid;

    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_valid;
    logic                   m_ready;

    modport slave (
        input  s_data, s_valid,
        output s_ready,
        output mac_data, mac_coeff, mac_valid, mac_clear,
        input  mac_ready, mac_acc, mac_acc_valid,
        output m_data, m_valid,
        input  m_ready
    );

    modport master (
        output s_data, s_valid,
        input  s_ready,
        input  mac_data, mac_coeff, mac_valid, mac_clear,
        output mac_ready, mac_acc, mac_acc_valid,
        input  m_data, m_valid,
        output m_ready
    );
endinterface

// File: rtl/fir_tap_store.sv
// Sample delay line and coefficient store: one write port each, combinational reads.
// Flush zeroes the delay line before a same-cycle sample write is applied.
module fir_tap_store #(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned COEFF_WIDTH = 18,
    parameter int unsigned NUM_TAPS    = 16,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   smp_we_i,
    input  logic [ADDR_WIDTH-1:0]  smp_waddr_i,
    input  logic [DATA_WIDTH-1:0]  smp_wdata_i,
    input  logic                   cf_we_i,
    input  logic [ADDR_WIDTH-1:0]  cf_waddr_i,
    input  logic [COEFF_WIDTH-1:0] cf_wdata_i,
    input  logic [ADDR_WIDTH-1:0]  smp_raddr_i,
    output logic [DATA_WIDTH-1:0]  smp_rdata_o,
    input  logic [ADDR_WIDTH-1:0]  cf_raddr_i,
    output logic [COEFF_WIDTH-1:0] cf_rdata_o
);

    logic [DATA_WIDTH-1:0]  delay_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0]  delay_d [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];
    logic [COEFF_WIDTH-1:0] coeff_d [NUM_TAPS];

    always_comb begin
        delay_d = delay_q;
        coeff_d = coeff_q;
        if (flush_i) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                delay_d[i] = '0;
            end
        end
        if (smp_we_i) begin
            delay_d[smp_waddr_i] = smp_wdata_i;
        end
        // Non-power-of-two depths leave unused addresses; drop writes to them.
        if (cf_we_i && (32'(cf_waddr_i) < NUM_TAPS)) begin
            coeff_d[cf_waddr_i] = cf_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                delay_q[i] <= '0;
                coeff_q[i] <= '0;
            end
        end else begin
            delay_q <= delay_d;
            coeff_q <= coeff_d;
        end
    end

    assign smp_rdata_o = delay_q[smp_raddr_i];
    assign cf_rdata_o  = coeff_q[cf_raddr_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR filter sequencer: one output per input sample, issuing NUM_TAPS MAC operations to an
// external MAC. Define FIR_SEQ_SAT_EN to saturate the output slice instead of truncating.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned COEFF_WIDTH = 18,
    parameter int unsigned ACC_WIDTH   = 48,
    parameter int unsigned NUM_TAPS    = 16,
    parameter int unsigned OUT_SHIFT   = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        flush,
    input  logic                        coeff_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coeff_addr,
    input  logic [COEFF_WIDTH-1:0]      coeff_wdata,
    fir_mac_sequencer_if.slave          bus,
    output logic                        busy,
    output logic [15:0]                 status
);

    localparam int unsigned AW   = $clog2(NUM_TAPS);
    localparam int unsigned CntW = $clog2(NUM_TAPS + 2);

    fir_state_e             state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          newest_q, newest_d;
    logic [AW-1:0]          tap_q, tap_d;
    logic [CntW-1:0]        acc_cnt_q, acc_cnt_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic                   cf_err_q, cf_err_d;
    logic                   live_q;

    logic                   smp_we, flush_en, cf_we_en;
    logic [AW-1:0]          smp_waddr, rd_idx;
    logic [DATA_WIDTH-1:0]  smp_rdata, acc_slice;
    logic [COEFF_WIDTH-1:0] cf_rdata;
    logic                   unused_acc;

`ifdef FIR_SEQ_SAT_EN
    logic sat_q, sat_d;
    logic acc_over;
    assign acc_over = |(bus.mac_acc >> (OUT_SHIFT + DATA_WIDTH));
`endif

    assign acc_slice  = DATA_WIDTH'(bus.mac_acc >> OUT_SHIFT);
    assign unused_acc = ^bus.mac_acc;
    assign rd_idx     = AW'(ring_sub(32'(newest_q), 32'(tap_q), NUM_TAPS));

    fir_tap_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .ADDR_WIDTH (AW)
    ) u_tap_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_en),
        .smp_we_i   (smp_we),
        .smp_waddr_i(smp_waddr),
        .smp_wdata_i(bus.s_data),
        .cf_we_i    (cf_we_en),
        .cf_waddr_i (coeff_addr),
        .cf_wdata_i (coeff_wdata),
        .smp_raddr_i(rd_idx),
        .smp_rdata_o(smp_rdata),
        .cf_raddr_i (tap_q),
        .cf_rdata_o (cf_rdata)
    );

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        newest_d      = newest_q;
        tap_d         = tap_q;
        acc_cnt_d     = acc_cnt_q;
        m_data_d      = m_data_q;
        cf_err_d      = cf_err_q;
`ifdef FIR_SEQ_SAT_EN
        sat_d         = sat_q;
`endif
        smp_we        = 1'b0;
        smp_waddr     = wr_ptr_q;
        flush_en      = 1'b0;
        cf_we_en      = 1'b0;
        bus.s_ready   = 1'b0;
        bus.mac_valid = 1'b0;
        bus.mac_clear = 1'b0;
        bus.mac_data  = '0;
        bus.mac_coeff = '0;

        // With enable low everything above holds and no handshake is offered.
        if (enable) begin
            if (coeff_we && (state_q != StIdle)) begin
                cf_err_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    bus.s_ready = live_q;
                    cf_we_en    = coeff_we;
                    flush_en    = flush;
                    if (flush) begin
                        smp_waddr = '0;
                        wr_ptr_d  = '0;
                    end
                    if (bus.s_valid && live_q) begin
                        smp_we   = 1'b1;
                        newest_d = smp_waddr;
                        wr_ptr_d = AW'(ring_inc(32'(smp_waddr), NUM_TAPS));
                        state_d  = StClear;
                    end
                end
                StClear: begin
                    bus.mac_valid = 1'b1;
                    bus.mac_clear = 1'b1;
                    if (bus.mac_acc_valid) begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                    if (bus.mac_ready) begin
                        tap_d     = '0;
                        acc_cnt_d = '0;
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    bus.mac_valid = 1'b1;
                    bus.mac_data  = smp_rdata;
                    bus.mac_coeff = cf_rdata;
                    if (bus.mac_acc_valid) begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                    if (bus.mac_ready) begin
                        if (tap_q == AW'(NUM_TAPS - 1)) begin
                            state_d = StDrain;
                        end else begin
                            tap_d = tap_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    // Clear result plus NUM_TAPS products: the last pulse carries the sum.
                    if (bus.mac_acc_valid) begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                        if (acc_cnt_q == CntW'(NUM_TAPS)) begin
`ifdef FIR_SEQ_SAT_EN
                            if (acc_over) begin
                                m_data_d = '1;
                                sat_d    = 1'b1;
                            end else begin
                                m_data_d = acc_slice;
                            end
`else
                            m_data_d = acc_slice;
`endif
                            state_d = StOut;
                        end
                    end
                end
                StOut: begin
                    if (bus.m_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            newest_q  <= '0;
            tap_q     <= '0;
            acc_cnt_q <= '0;
            m_data_q  <= '0;
            cf_err_q  <= 1'b0;
            live_q    <= 1'b0;
`ifdef FIR_SEQ_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            newest_q  <= newest_d;
            tap_q     <= tap_d;
            acc_cnt_q <= acc_cnt_d;
            m_data_q  <= m_data_d;
            cf_err_q  <= cf_err_d;
            live_q    <= 1'b1;
`ifdef FIR_SEQ_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign bus.m_valid = (state_q == StOut);
    assign bus.m_data  = m_data_q;
    assign busy        = (state_q != StIdle);

    always_comb begin
        status                                  = '0;
        status[StatStateLsb +: 3]               = state_q;
        status[StatBusyBit]                     = busy;
        status[StatCoeffErrBit]                 = cf_err_q;
        status[StatTapLsb +: StatTapWidth]      = StatTapWidth'(tap_q);
`ifdef FIR_SEQ_SAT_EN
        status[StatSatBit]                      = sat_q;
`endif
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (NUM_TAPS=4, 8-bit data/coeff) with a one-cycle
// behavioural MAC. Honours FIR_SEQ_SAT_EN when choosing the overflow expectation.
module tb_fir_mac_sequencer;

    logic       clk;
    logic       rst_n = 1'b1;
    logic       enable;
    logic       flush;
    logic       coeff_we;
    logic [1:0] coeff_addr;
    logic [7:0] coeff_wdata;
    logic       busy;
    logic [15:0] status;

    int n_vec = 0;
    int n_err = 0;

`ifdef FIR_SEQ_SAT_EN
    localparam logic [7:0] SatExp  = 8'd255;
    localparam logic       SatFlag = 1'b1;
`else
    localparam logic [7:0] SatExp  = 8'd44;
    localparam logic       SatFlag = 1'b0;
`endif

    fir_mac_sequencer_if #(.DATA_WIDTH(8), .COEFF_WIDTH(8), .ACC_WIDTH(24)) bus ();

    fir_mac_sequencer #(
        .DATA_WIDTH (8),
        .COEFF_WIDTH(8),
        .ACC_WIDTH  (24),
        .NUM_TAPS   (4),
        .OUT_SHIFT  (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .flush      (flush),
        .coeff_we   (coeff_we),
        .coeff_addr (coeff_addr),
        .coeff_wdata(coeff_wdata),
        .bus        (bus),
        .busy       (busy),
        .status     (status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MAC unit: accepts every operand, result valid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mac_acc       <= '0;
            bus.mac_acc_valid <= 1'b0;
        end else begin
            bus.mac_acc_valid <= bus.mac_valid && bus.mac_ready;
            if (bus.mac_valid && bus.mac_ready) begin
                bus.mac_acc <= bus.mac_clear ? 24'd0
                             : bus.mac_acc + 24'(bus.mac_data) * 24'(bus.mac_coeff);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_coeff(input logic [1:0] addr, input logic [7:0] val);
        @(negedge clk);
        coeff_we = 1'b1; coeff_addr = addr; coeff_wdata = val;
        @(negedge clk);
        coeff_we = 1'b0;
    endtask

    task automatic send_sample(input logic [7:0] v);
        int n;
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = v;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic take_output(input logic [7:0] exp_out, input string tag, input int hold);
        int n;
        n = 0;
        while (!bus.m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mvalid"}, 32'(bus.m_valid), 32'd1);
        check(tag, 32'(bus.m_data), 32'(exp_out));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, 32'(bus.m_data), 32'(exp_out));
            check({tag, "_hold_sready"}, 32'(bus.s_ready), 32'd0);
            check({tag, "_hold_macvalid"}, 32'(bus.mac_valid), 32'd0);
            check({tag, "_hold_state"}, 32'(status[2:0]), 32'd4);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check({tag, "_back_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        enable = 1'b1; flush = 1'b0; coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0; bus.mac_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_status", 32'(status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mvalid", 32'(bus.m_valid), 32'd0);
        check("rst_macvalid", 32'(bus.mac_valid), 32'd0);
        check("rst_macclear", 32'(bus.mac_clear), 32'd0);
        check("rst_sready", 32'(bus.s_ready), 32'd0);
        check("rst_mdata", 32'(bus.m_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sready", 32'(bus.s_ready), 32'd1);

        // Disabled: no handshake, nothing starts.
        enable = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'd77;
        repeat (3) @(negedge clk);
        check("dis_sready", 32'(bus.s_ready), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        bus.s_valid = 1'b0; enable = 1'b1;

        // Impulse response through coefficients 1,2,3,4.
        write_coeff(2'd0, 8'd1); write_coeff(2'd1, 8'd2);
        write_coeff(2'd2, 8'd3); write_coeff(2'd3, 8'd4);
        send_sample(8'd1); take_output(8'd1, "imp0", 0);
        send_sample(8'd0); take_output(8'd2, "imp1", 0);
        send_sample(8'd0); take_output(8'd3, "imp2", 0);
        send_sample(8'd0); take_output(8'd4, "imp3", 0);

        // Running sum with unit coefficients after a flush.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int i = 0; i < 4; i++) write_coeff(2'(i), 8'd1);
        send_sample(8'd5); take_output(8'd5, "sum0", 0);
        send_sample(8'd6); take_output(8'd11, "sum1", 0);
        send_sample(8'd7); take_output(8'd18, "sum2", 0);
        send_sample(8'd8); take_output(8'd26, "sum3", 0);

        // Backpressure: 10 cycles with m_ready low; delay line becomes {9,6,7,8}.
        send_sample(8'd9); take_output(8'd30, "hold", 10);

        // Coefficient write while running is dropped and flagged.
        send_sample(8'd10);
        n = 0;
        while (status[2:0] != 3'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_wdata = 8'd9;
        @(negedge clk);
        coeff_we = 1'b0;
        check("cwe_err", 32'(status[4]), 32'd1);
        take_output(8'd34, "cwe_out", 0);
        send_sample(8'd1); take_output(8'd28, "cwe_keep", 0);

        // Reset in the middle of RUN at tap 2.
        send_sample(8'd2);
        n = 0;
        while (!(status[2:0] == 3'd2 && status[15:8] == 8'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_tap2_reached", 32'(status[15:8]), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_status", 32'(status), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_macvalid", 32'(bus.mac_valid), 32'd0);
        check("mid_rst_mvalid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_sready", 32'(bus.s_ready), 32'd0);
        check("mid_rst_mdata", 32'(bus.m_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_valid) seen++;
        end
        check("mid_rst_no_mvalid", 32'(seen), 32'd0);

        // Overflow: 3 * 100 = 300 does not fit 8 bits.
        write_coeff(2'd0, 8'd100);
        send_sample(8'd3); take_output(SatExp, "sat", 0);
        check("sat_flag", 32'(status[5]), 32'(SatFlag));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: sample and output width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 18: coefficient width.
REQ-003 SHALL have parameter ACC_WIDTH, default 48: MAC accumulator width.
REQ-004 SHALL have parameter NUM_TAPS, default 16: taps, range 2..256.
REQ-005 SHALL have parameter OUT_SHIFT, default 0: LSB index of the output slice of the accumulator.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  global enable; low freezes all state.
REQ-010 s_data/s_valid/s_ready  in/in/out  DATA_WIDTH/1/1  input sample stream.
REQ-011 coeff_we/coeff_addr/coeff_wdata  in  1/clog2(NUM_TAPS)/COEFF_WIDTH  coefficient write port.
REQ-012 flush  in  1  clear the delay line.
REQ-013 mac_data/mac_coeff/mac_valid/mac_clear  out  DATA_WIDTH/COEFF_WIDTH/1/1  MAC operand issue.
REQ-014 mac_ready  in  1  MAC accepts the operand.
REQ-015 mac_acc/mac_acc_valid  in  ACC_WIDTH/1  MAC result.
REQ-016 m_data/m_valid/m_ready  out/out/in  DATA_WIDTH/1/1  filtered output stream.
REQ-017 busy/status  out  1/16  activity flag and status word.

Function
REQ-018 SHALL use FSM states IDLE=0, CLEAR=1, RUN=2, DRAIN=3, OUT=4.
REQ-019 IDLE: s_ready=enable; on s_valid&s_ready, write the sample at wr_ptr, set newest=wr_ptr, advance wr_ptr modulo NUM_TAPS, go to CLEAR.
REQ-020 CLEAR: drive mac_valid=1, mac_clear=1, mac_data=0, mac_coeff=0; on mac_ready, set tap=0, acc_cnt=0, go to RUN.
REQ-021 RUN: drive mac_valid=1, mac_clear=0, mac_data=delay[(newest-tap) mod NUM_TAPS], mac_coeff=coeff[tap]; on mac_ready, increment tap; at tap==NUM_TAPS-1 accepted, go to DRAIN.
REQ-022 SHALL increment acc_cnt on every mac_acc_valid in CLEAR/RUN/DRAIN; in DRAIN, when acc_cnt reaches NUM_TAPS+1 (counting the current pulse), capture mac_acc slice [OUT_SHIFT+DATA_WIDTH-1:OUT_SHIFT] into m_data and go to OUT.
REQ-023 OUT: m_valid=1 with m_data stable until m_ready; then go to IDLE; s_ready=0 throughout.
REQ-024 SHALL drive mac_valid=0 and mac_clear=0 in IDLE, DRAIN and OUT.
REQ-025 SHALL hold operands stable while mac_valid=1 and mac_ready=0.
REQ-026 SHALL apply coeff_we only in IDLE (same-cycle accept allowed; the write lands before RUN); writes in other states SHALL be dropped and SHALL set sticky status[4].
REQ-027 SHALL zero all delay-line entries and wr_ptr on flush in IDLE; flush outside IDLE SHALL be ignored; flush with a same-cycle accept SHALL clear first, then write the sample.
REQ-028 While enable=0: FSM, counters and memories frozen; s_ready=0; mac_valid=0; m_valid holds.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 status: [2:0] state, [3] busy, [4] coeff write error, [5] saturation sticky, [15:8] tap; others 0.

Reset
REQ-031 On rst_n low: state IDLE; wr_ptr, newest, tap, acc_cnt, delay line, coefficients, m_data, status stickies = 0; m_valid, mac_valid, mac_clear, busy = 0; s_ready = 0.
REQ-032 Reset mid-run SHALL abandon the operation; no m_valid SHALL follow.

Configuration
REQ-033 Macro FIR_SEQ_SAT_EN defined: if any mac_acc bit above the slice is 1, m_data=all ones and status[5] sets (sticky).
REQ-034 FIR_SEQ_SAT_EN undefined: plain bit-slice truncation; status[5] tied 0.

Structure
REQ-035 SHALL place the FSM state encoding and status bit-index constants in the shared package fir_pkg.
REQ-036 SHALL place the delay line and coefficient store in sub-module fir_tap_store (one write port each, combinational read).

Verification (NUM_TAPS=4, OUT_SHIFT=0, driving mac_unit)
REQ-037 coeff 1,2,3,4; samples 1,0,0,0 -> m_data 1,2,3,4.
REQ-038 coeff 1,1,1,1; samples 5,6,7,8 -> m_data 5,11,18,26.
REQ-039 m_ready held low 10 cycles in OUT -> m_data stable, s_ready=0, no new MAC issue.
REQ-040 coeff_we during RUN -> coeff unchanged, status[4]=1.
REQ-041 rst_n pulsed during RUN tap 2 -> all outputs at reset values, no m_valid.
REQ-042 FIR_SEQ_SAT_EN with DATA_WIDTH=8, sum 300 -> m_data=255, status[5]=1; without the macro -> m_data=44.
